iq_window_avg: RTL and testbench



---
 rtl/iq_window_avg.sv | 123 ++++++++++++
 tb/tb_iq_window_avg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/iq_window_avg.sv
// Windowed I/Q averager: averages 2^LOG2_N valid samples after a trigger, emits a packed 64-bit result.
// Build option: define IQ_WINDOW_AVG_ROUND_EN for round-half-up averaging instead of floor.
module iq_window_avg #(
    parameter int LOG2_N = 2
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    input  logic        trig,
    input  logic [17:0] in_i,
    input  logic [17:0] in_q,
    input  logic        in_vld,
    output logic [63:0] output_V,
    output logic        output_V_ap_vld,
    output logic        busy,
    output logic [7:0]  missed_trig,
    output logic [1:0]  dbg_state
);

    localparam int AW = 18 + LOG2_N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [AW-1:0] acc_i, acc_q;
    logic signed [AW-1:0] samp_i, samp_q;
    logic signed [AW-1:0] sum_i, sum_q;
    logic signed [AW-1:0] fin_i, fin_q;
    logic [LOG2_N-1:0]    cnt;
    logic                 start_win, take, last;
    logic [17:0]          avg_i, avg_q;
    logic                 unused_frac;

    assign samp_i = {{LOG2_N{in_i[17]}}, in_i};
    assign samp_q = {{LOG2_N{in_q[17]}}, in_q};
    assign sum_i  = acc_i + samp_i;
    assign sum_q  = acc_q + samp_q;

`ifdef IQ_WINDOW_AVG_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(1 << (LOG2_N - 1));
    assign fin_i = sum_i + RND;
    assign fin_q = sum_q + RND;
`else
    assign fin_i = sum_i;
    assign fin_q = sum_q;
`endif

    // Arithmetic shift right by LOG2_N is just the upper 18 bits of the signed sum.
    assign avg_i       = fin_i[AW-1:LOG2_N];
    assign avg_q       = fin_q[AW-1:LOG2_N];
    assign unused_frac = ^{fin_i[LOG2_N-1:0], fin_q[LOG2_N-1:0]};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_win = 1'b0;
        take      = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ap_start && trig) begin
                    start_win = 1'b1;
                    state_nxt = S_ACQ;
                end
            end
            S_ACQ: begin
                if (!ap_start) begin
                    state_nxt = S_IDLE;
                end else if (in_vld) begin
                    take = 1'b1;
                    if (cnt == '1) begin
                        last      = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A sample arriving with the accepted trigger counts as sample 1.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            output_V    <= '0;
            missed_trig <= '0;
        end else begin
            if (start_win) begin
                acc_i <= in_vld ? samp_i : '0;
                acc_q <= in_vld ? samp_q : '0;
                cnt   <= in_vld ? LOG2_N'(1) : '0;
            end else if (take) begin
                if (last) begin
                    output_V <= {{14{avg_q[17]}}, avg_q, {14{avg_i[17]}}, avg_i};
                    cnt      <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + 1'b1;
                end
            end
            if ((state != S_IDLE) && trig && (missed_trig != 8'hFF))
                missed_trig <= missed_trig + 8'd1;
        end
    end

    assign output_V_ap_vld = (state == S_DONE);
    assign busy            = (state != S_IDLE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_iq_window_avg.sv
// Directed bench for iq_window_avg (LOG2_N=2); expected results are hand-computed window averages.
module tb_iq_window_avg;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start, trig, in_vld;
    logic [17:0] in_i, in_q;
    logic [63:0] output_V;
    logic        output_V_ap_vld, busy;
    logic [7:0]  missed_trig;
    logic [1:0]  dbg_state;

    iq_window_avg #(.LOG2_N(2)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .trig            (trig),
        .in_i            (in_i),
        .in_q            (in_q),
        .in_vld          (in_vld),
        .output_V        (output_V),
        .output_V_ap_vld (output_V_ap_vld),
        .busy            (busy),
        .missed_trig     (missed_trig),
        .dbg_state       (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    // I sums to 40 -> 10; Q sums to -10 -> floor -3, rounded -2.
`ifdef IQ_WINDOW_AVG_ROUND_EN
    localparam logic [63:0] EXP_A = 64'hFFFFFFFE_0000000A;
`else
    localparam logic [63:0] EXP_A = 64'hFFFFFFFD_0000000A;
`endif
    localparam logic [63:0] EXP_B = 64'hFFFE0000_0001FFFF;

    int a_i[4] = '{4, 8, 12, 16};
    int a_q[4] = '{-1, -2, -3, -4};
    int b_i[4] = '{131071, 131071, 131071, 131071};
    int b_q[4] = '{-131072, -131072, -131072, -131072};
    int gap[7] = '{1, 0, 0, 1, 0, 1, 1};

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge; any output pulse is scored against the expected queue.
    task automatic step();
        @(posedge ap_clk);
        #1;
        if (output_V_ap_vld) begin
            n_pulses++;
            if (exp_q.size() == 0) check("vld_unexpected", 64'd1, 64'd0);
            else                   check("output_V", output_V, exp_q.pop_front());
        end
    endtask

    task automatic drive(input logic trg, input logic v, input int i, input int q);
        trig   = trg;
        in_vld = v;
        in_i   = 18'(i);
        in_q   = 18'(q);
        step();
        trig   = 1'b0;
        in_vld = 1'b0;
    endtask

    initial begin
        int idx;
        int p0;
        ap_rst = 1'b1; ap_start = 1'b0; trig = 1'b0; in_vld = 1'b0;
        in_i = '0; in_q = '0;
        step(); step();
        check("rst_output_V", output_V, 64'd0);
        check("rst_vld", {63'd0, output_V_ap_vld}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_missed", {56'd0, missed_trig}, 64'd0);

        // reset wins over a simultaneous trigger
        ap_start = 1'b1; trig = 1'b1; in_vld = 1'b1; in_i = 18'd5;
        step();
        trig = 1'b0; in_vld = 1'b0;
        check("rst_prio_busy", {63'd0, busy}, 64'd0);
        ap_rst = 1'b0;

        // basic window, consecutive samples
        exp_q.push_back(EXP_A);
        for (int k = 0; k < 4; k++) begin
            drive(k == 0, 1'b1, a_i[k], a_q[k]);
            if (k == 0) check("t1_busy", {63'd0, busy}, 64'd1);
            check($sformatf("t1_vld_s%0d", k + 1), {63'd0, output_V_ap_vld}, (k == 3) ? 64'd1 : 64'd0);
        end
        drive(0, 0, 0, 0);
        check("t1_vld_drop", {63'd0, output_V_ap_vld}, 64'd0);
        check("t1_idle", {63'd0, busy}, 64'd0);
        check("t1_hold", output_V, EXP_A);

        // full-scale samples, no overflow
        exp_q.push_back(EXP_B);
        for (int k = 0; k < 4; k++) drive(k == 0, 1'b1, b_i[k], b_q[k]);
        check("t2_vld", {63'd0, output_V_ap_vld}, 64'd1);
        drive(0, 0, 0, 0);

        // gapped in_vld
        exp_q.push_back(EXP_A);
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, gap[c] != 0, (gap[c] != 0) ? a_i[idx] : 0, (gap[c] != 0) ? a_q[idx] : 0);
            idx += gap[c];
            if (c == 5) check("t3_vld_early", {63'd0, output_V_ap_vld}, 64'd0);
            if (c == 6) check("t3_vld", {63'd0, output_V_ap_vld}, 64'd1);
        end
        drive(0, 0, 0, 0);

        // ignored triggers: three in ACQ, one in DONE
        p0 = n_pulses;
        exp_q.push_back(EXP_A);
        drive(1, 1, a_i[0], a_q[0]);
        drive(1, 1, a_i[1], a_q[1]);
        drive(1, 0, 0, 0);
        drive(1, 1, a_i[2], a_q[2]);
        drive(0, 1, a_i[3], a_q[3]);
        check("t4_vld", {63'd0, output_V_ap_vld}, 64'd1);
        drive(1, 0, 0, 0);
        check("t4_missed", {56'd0, missed_trig}, 64'd4);
        check("t4_no_start", {63'd0, busy}, 64'd0);
        check("t4_pulses", 64'(n_pulses - p0), 64'd1);

        // saturation
        drive(1, 0, 0, 0);
        check("t5_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 300; k++) drive(1, 0, 0, 0);
        check("t5_sat", {56'd0, missed_trig}, 64'd255);
        ap_start = 1'b0;
        drive(0, 0, 0, 0);
        check("t5_abort_busy", {63'd0, busy}, 64'd0);
        ap_start = 1'b1;

        // ap_start dropped after sample 2
        p0 = n_pulses;
        drive(1, 1, a_i[0], a_q[0]);
        drive(0, 1, a_i[1], a_q[1]);
        ap_start = 1'b0;
        drive(0, 1, a_i[2], a_q[2]);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_vld", {63'd0, output_V_ap_vld}, 64'd0);
        check("t6_hold", output_V, EXP_A);
        ap_start = 1'b1;
        drive(0, 1, a_i[3], a_q[3]);
        drive(0, 0, 0, 0);
        check("t6_pulses", 64'(n_pulses - p0), 64'd0);
        exp_q.push_back(EXP_B);
        for (int k = 0; k < 4; k++) drive(k == 0, 1'b1, b_i[k], b_q[k]);
        check("t6_fresh_vld", {63'd0, output_V_ap_vld}, 64'd1);
        drive(0, 0, 0, 0);

        // reset mid-window after sample 3
        for (int k = 0; k < 3; k++) drive(k == 0, 1'b1, a_i[k], a_q[k]);
        ap_rst = 1'b1;
        drive(0, 0, 0, 0);
        ap_rst = 1'b0;
        check("t7_output_V", output_V, 64'd0);
        check("t7_vld", {63'd0, output_V_ap_vld}, 64'd0);
        check("t7_busy", {63'd0, busy}, 64'd0);
        check("t7_missed", {56'd0, missed_trig}, 64'd0);
        drive(0, 1, a_i[3], a_q[3]);
        check("t7_stray_busy", {63'd0, busy}, 64'd0);
        exp_q.push_back(EXP_A);
        for (int k = 0; k < 4; k++) begin
            drive(k == 0, 1'b1, a_i[k], a_q[k]);
            if (k == 2) check("t7_not_early", {63'd0, output_V_ap_vld}, 64'd0);
            if (k == 3) check("t7_vld", {63'd0, output_V_ap_vld}, 64'd1);
        end
        drive(0, 0, 0, 0);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
